// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: consumer-side controller for a PS/2 keyboard receiver FIFO.
// This module pops scan-code bytes with the ready/nextdata_n handshake. It
// decodes set-2 prefixes (E0 = extended key, F0 = break). It keeps the state
// of the last key and a press counter. It emits a one-cycle event each time
// the key state changes.
//
// Ports:
//   clk        system clock, rising edge
//   clrn       async active-low reset
//   en         allow popping bytes from the receiver
//   ready      receiver FIFO non-empty
//   data[7:0]  receiver FIFO head byte
//   overflow   receiver FIFO overflow flag
//   nextdata_n active-low pop strobe, one cycle per consumed byte
//   key_code   last make/break code (prefixes stripped)
//   key_ext    key_code carried an E0 prefix
//   key_down   key_code currently held
//   press_cnt  count of new key presses (wraps)
//   evt_valid  one-cycle pulse when the key outputs update
//   evt_make   qualifies evt_valid: 1 = make, 0 = break
//   ovf_err    sticky overflow indicator
module ps2_kbd_ctrl #(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             en,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_down,
  output logic [CNT_W-1:0] press_cnt,
  output logic             evt_valid,
  output logic             evt_make,
  output logic             ovf_err
);

  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

  localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES);

  state_t     state;
  logic [3:0] gap_cnt;
  logic       ext_pend;
  logic       brk_pend;
  logic       is_repeat;

  // A make of the key that is already held is typematic auto-repeat.
  // It is not counted as a new press.
  assign is_repeat = key_down && (data == key_code) && (ext_pend == key_ext);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      nextdata_n <= 1'b1;
      key_code   <= '0;
      key_ext    <= 1'b0;
      key_down   <= 1'b0;
      press_cnt  <= '0;
      evt_valid  <= 1'b0;
      evt_make   <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      evt_valid <= 1'b0;
      if (overflow) ovf_err <= 1'b1;

      case (state)
        IDLE: begin
          if (en && ready) begin
            state      <= POP;
            nextdata_n <= 1'b0;
            // Decode happens at the capture edge, so the event appears in the POP cycle.
            if (data == 8'hE0) begin
              ext_pend <= 1'b1;
            end else if (data == 8'hF0) begin
              brk_pend <= 1'b1;
            end else if (data != 8'hE1) begin
              evt_valid <= 1'b1;
              key_code  <= data;
              key_ext   <= ext_pend;
              ext_pend  <= 1'b0;
              brk_pend  <= 1'b0;
              if (brk_pend) begin
                key_down <= 1'b0;
                evt_make <= 1'b0;
              end else begin
                key_down <= 1'b1;
                evt_make <= 1'b1;
                if (!is_repeat) press_cnt <= press_cnt + CNT_W'(1);
              end
            end
          end
        end
        POP: begin
          nextdata_n <= 1'b1;
          gap_cnt    <= GAP_LD;
          state      <= GAP;
        end
        GAP: begin
          // ready/data are ignored here so the receiver can settle after the pop.
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt == 4'd1) state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          nextdata_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl. A queue models the receiver FIFO.
// A reference decoder pushes the expected events when each byte is queued.
// A negedge monitor pops those expected events and compares them with the
// DUT events.
module tb_ps2_kbd_ctrl;

  localparam int GAP   = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             clrn;
  logic             en;
  logic             ready;
  logic [7:0]       data;
  logic             overflow;
  logic             nextdata_n;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_down;
  logic [CNT_W-1:0] press_cnt;
  logic             evt_valid;
  logic             evt_make;
  logic             ovf_err;

  ps2_kbd_ctrl #(.GAP_CYCLES(GAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .clrn(clrn), .en(en), .ready(ready), .data(data),
    .overflow(overflow), .nextdata_n(nextdata_n), .key_code(key_code),
    .key_ext(key_ext), .key_down(key_down), .press_cnt(press_cnt),
    .evt_valid(evt_valid), .evt_make(evt_make), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       make;
    logic [7:0] code;
    logic       ext;
    logic       down;
    logic [7:0] cnt;
  } evt_t;

  logic [7:0] fifo_q[$];
  evt_t       exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int npop  = 0;
  int nevt  = 0;
  int npush = 0;
  int last_pop = -100;

  // reference decoder state
  logic       m_ext, m_brk, m_kext, m_kdown;
  logic [7:0] m_kcode, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic upd_fifo();
    ready = (fifo_q.size() != 0);
    data  = ready ? fifo_q[0] : 8'h00;
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_kext = 0; m_kdown = 0; m_kcode = 0; m_cnt = 0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    evt_t e;
    fifo_q.push_back(b);
    npush++;
    upd_fifo();
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b != 8'hE1) begin
      if (m_brk) begin
        m_kdown = 0;
        e.make = 0;
      end else begin
        if (!(m_kdown && b == m_kcode && m_ext == m_kext)) m_cnt = m_cnt + 8'd1;
        m_kdown = 1;
        e.make = 1;
      end
      m_kcode = b;
      m_kext  = m_ext;
      e.code = b; e.ext = m_ext; e.down = m_kdown; e.cnt = m_cnt;
      exp_q.push_back(e);
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  // receiver FIFO: the head is dropped on the edge where the pop strobe is low
  always @(posedge clk) begin
    cyc++;
    if (clrn && !nextdata_n && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      upd_fifo();
    end
  end

  // monitor: pop strobes and events sampled away from the active edge
  always @(negedge clk) begin
    if (clrn && !nextdata_n) begin
      npop++;
      chk("pop_gap", 32'(cyc - last_pop >= 2 + GAP), 32'd1);
      last_pop = cyc;
    end
    if (clrn && evt_valid) begin
      evt_t e;
      nevt++;
      if (exp_q.size() == 0) begin
        chk("unexp_evt", {24'd0, key_code}, 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("evt_make", 32'(evt_make), 32'(e.make));
        chk("key_code", 32'(key_code), 32'(e.code));
        chk("key_ext",  32'(key_ext),  32'(e.ext));
        chk("key_down", 32'(key_down), 32'(e.down));
        chk("press_cnt", 32'(press_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk("drain_timeout", 32'd1, 32'd0);
    repeat (GAP + 4) @(negedge clk);
    chk("pops", 32'(npop), 32'(npush));
  endtask

  initial begin
    int p0, e0, n;
    logic [7:0] c0, b;
    clrn = 0; en = 1; overflow = 0;
    model_reset();
    upd_fifo();
    repeat (3) @(negedge clk);
    chk("rst_nextdata_n", 32'(nextdata_n), 32'd1);
    chk("rst_key_code",  32'(key_code), 32'd0);
    chk("rst_key_down",  32'(key_down), 32'd0);
    chk("rst_press_cnt", 32'(press_cnt), 32'd0);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_ovf_err",   32'(ovf_err), 32'd0);
    clrn = 1;
    @(negedge clk);

    // single make, then break
    push_byte(8'h1C);
    drain();
    chk("make_1c_down", 32'(key_down), 32'd1);
    push_byte(8'hF0); push_byte(8'h1C);
    drain();
    chk("brk_1c_cnt", 32'(press_cnt), 32'd1);

    // extended make/break
    push_byte(8'hE0); push_byte(8'h75);
    push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
    drain();
    chk("ext_cnt", 32'(press_cnt), 32'd2);

    // typematic repeat, then a new key
    push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h32);
    drain();
    chk("typ_code", 32'(key_code), 32'h32);
    chk("typ_cnt",  32'(press_cnt), 32'd4);

    // the controller holds off while en is low
    en = 0;
    p0 = npop; e0 = nevt;
    push_byte(8'h5A);
    repeat (20) @(negedge clk);
    chk("en0_pops", 32'(npop - p0), 32'd0);
    chk("en0_evts", 32'(nevt - e0), 32'd0);
    en = 1;
    n = 0;
    while (npop == p0 && n < 4) begin @(negedge clk); n++; end
    chk("en1_pop", 32'(npop - p0), 32'd1);
    drain();

    // sticky overflow flag
    overflow = 1;
    @(negedge clk);
    overflow = 0;
    repeat (5) @(negedge clk);
    chk("ovf_sticky", 32'(ovf_err), 32'd1);

    // 256 press/release pairs wrap the counter back to its start value
    c0 = press_cnt;
    for (int i = 0; i < 256; i++) begin
      b = 8'((i % 200) + 1);
      push_byte(b); push_byte(8'hF0); push_byte(b);
    end
    drain();
    chk("wrap_cnt", 32'(press_cnt), 32'(c0));

    // reset after a lone F0 drops the pending break
    push_byte(8'hF0);
    drain();
    clrn = 0;
    model_reset();
    @(negedge clk);
    chk("rst2_ovf_err", 32'(ovf_err), 32'd0);
    chk("rst2_cnt", 32'(press_cnt), 32'd0);
    clrn = 1;
    @(negedge clk);
    push_byte(8'h1C);
    drain();
    chk("post_rst_make", 32'(key_down), 32'd1);
    chk("post_rst_cnt",  32'(press_cnt), 32'd1);
    chk("leftover", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
